// File: rtl/mux_arb_nto1_pkg.sv
// Shared definitions for the N-to-1 arbitrated mux and later bus blocks:
// arbitration mode constants and the channel-index width helper.
package mux_arb_nto1_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    // Index width for n channels, never narrower than one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_arb_nto1_if.sv
// Handshake bundle for mux_arb_nto1: N request channels in, one registered word out.
interface mux_arb_nto1_if
    import mux_arb_nto1_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = sel_w(N)
);
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_arb_nto1_arb_rr_pick.sv
// Combinational request picker: lowest requester at or above ptr, wrapping to the
// lowest below ptr (round-robin), or simply the lowest requester (fixed priority).
module arb_rr_pick
    import mux_arb_nto1_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = sel_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  arb_mode_e        mode,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic hit;

    // First pass covers i >= ptr (all i in fixed mode); second pass supplies the wrap.
    always_comb begin
        gnt_idx = '0;
        gnt_any = |req;
        hit     = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!hit && req[k] && (mode == ARB_FIXED || k >= 32'(ptr))) begin
                gnt_idx = SEL_W'(k);
                hit     = 1'b1;
            end
        end
        for (int unsigned k = 0; k < N; k++) begin
            if (!hit && req[k]) begin
                gnt_idx = SEL_W'(k);
                hit     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_nto1.sv
// Registered N-to-1 multiplexer with valid/ready handshakes on every channel and
// round-robin or fixed-priority arbitration; one transfer per cycle under back-pressure.
module mux_arb_nto1
    import mux_arb_nto1_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned RR    = MODE_RR,
    parameter int unsigned SEL_W = sel_w(N)
) (
    input  logic          clk,
    input  logic          reset,
    mux_arb_nto1_if.slave bus
);

    localparam arb_mode_e MODE = (RR != MODE_FIXED) ? ARB_RR : ARB_FIXED;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;
    logic             load;
    logic             xfer;
    logic             gnt_any;
    logic [SEL_W-1:0] gnt_idx;

    arb_rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .req     (bus.in_valid),
        .ptr     (ptr_q),
        .mode    (MODE),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        load         = !out_valid_q || bus.out_ready;
        xfer         = load && gnt_any && !reset;
        bus.in_ready = '0;
        if (xfer) begin
            bus.in_ready[gnt_idx] = 1'b1;
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        // An empty load slot clears valid but leaves the stale word and index in place.
        if (load) begin
            out_valid_d = gnt_any;
            if (gnt_any) begin
                out_data_d = bus.in_data[32'(gnt_idx) * WIDTH +: WIDTH];
                out_sel_d  = gnt_idx;
                if (MODE == ARB_RR) begin
                    ptr_d = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + SEL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Bench for mux_arb_nto1: three instances (N=4 round-robin, N=4 fixed, N=3 round-robin)
// checked cycle by cycle against a queue-free arithmetic reference model.
module tb_mux_arb_nto1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mux_arb_nto1_if #(.WIDTH(8), .N(4), .SEL_W(2)) ia ();
    mux_arb_nto1_if #(.WIDTH(8), .N(4), .SEL_W(2)) ib ();
    mux_arb_nto1_if #(.WIDTH(8), .N(3), .SEL_W(2)) ic ();

    mux_arb_nto1 #(.WIDTH(8), .N(4), .RR(1), .SEL_W(2)) dut_a (.clk(clk), .reset(reset), .bus(ia));
    mux_arb_nto1 #(.WIDTH(8), .N(4), .RR(0), .SEL_W(2)) dut_b (.clk(clk), .reset(reset), .bus(ib));
    mux_arb_nto1 #(.WIDTH(8), .N(3), .RR(1), .SEL_W(2)) dut_c (.clk(clk), .reset(reset), .bus(ic));

    int n_assert = 0;
    int n_fail   = 0;

    // Stimulus per unit
    logic [3:0]  sv [3];
    logic [31:0] sd [3];
    logic        sr [3];

    // Reference model per unit
    int         nch [3] = '{4, 4, 3};
    bit         rrm [3] = '{1'b1, 1'b0, 1'b1};
    int         m_ptr [3];
    bit         m_v   [3];
    logic [7:0] m_d   [3];
    int         m_sel [3];

    logic [7:0] rrdat [4] = '{8'h10, 8'h21, 8'h32, 8'h43};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_ready(int u);
        case (u)
            0:       return 32'(ia.in_ready);
            1:       return 32'(ib.in_ready);
            default: return 32'(ic.in_ready);
        endcase
    endfunction

    function automatic logic [31:0] obs_valid(int u);
        case (u)
            0:       return 32'(ia.out_valid);
            1:       return 32'(ib.out_valid);
            default: return 32'(ic.out_valid);
        endcase
    endfunction

    function automatic logic [31:0] obs_data(int u);
        case (u)
            0:       return 32'(ia.out_data);
            1:       return 32'(ib.out_data);
            default: return 32'(ic.out_data);
        endcase
    endfunction

    function automatic logic [31:0] obs_sel(int u);
        case (u)
            0:       return 32'(ia.out_sel);
            1:       return 32'(ib.out_sel);
            default: return 32'(ic.out_sel);
        endcase
    endfunction

    // Spec rule: scan channels starting at ptr (RR) or at 0 (fixed), modulo N.
    function automatic int pick(int u);
        for (int k = 0; k < nch[u]; k++) begin
            int i;
            i = rrm[u] ? (m_ptr[u] + k) % nch[u] : k;
            if (sv[u][i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            m_ptr[u] = 0; m_v[u] = 1'b0; m_d[u] = 8'h00; m_sel[u] = 0;
        end
    endtask

    task automatic drive();
        ia.in_valid = sv[0];      ia.in_data = sd[0];        ia.out_ready = sr[0];
        ib.in_valid = sv[1];      ib.in_data = sd[1];        ib.out_ready = sr[1];
        ic.in_valid = sv[2][2:0]; ic.in_data = sd[2][23:0];  ic.out_ready = sr[2];
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle();
        int g [3];
        bit ld [3];
        drive();
        #1;
        for (int u = 0; u < 3; u++) begin
            ld[u] = !m_v[u] || sr[u];
            g[u]  = pick(u);
            chk($sformatf("ready_u%0d", u), obs_ready(u),
                (ld[u] && g[u] >= 0) ? (32'd1 << g[u]) : 32'd0);
        end
        @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            if (ld[u]) begin
                if (g[u] >= 0) begin
                    m_v[u]   = 1'b1;
                    m_d[u]   = sd[u][g[u]*8 +: 8];
                    m_sel[u] = g[u];
                    if (rrm[u]) m_ptr[u] = (g[u] + 1) % nch[u];
                end else begin
                    m_v[u] = 1'b0;
                end
            end
            chk($sformatf("valid_u%0d", u), obs_valid(u), 32'(m_v[u]));
            chk($sformatf("data_u%0d", u),  obs_data(u),  32'(m_d[u]));
            chk($sformatf("sel_u%0d", u),   obs_sel(u),   32'(m_sel[u]));
        end
        chk("sel_range_u2", 32'(obs_sel(2) < 3), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("%s_valid_u%0d", tag, u), obs_valid(u), 32'd0);
            chk($sformatf("%s_ready_u%0d", tag, u), obs_ready(u), 32'd0);
            chk($sformatf("%s_data_u%0d", tag, u),  obs_data(u),  32'd0);
        end
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            sv[u] = 4'hF; sd[u] = $urandom; sr[u] = 1'b1;
        end
        drive();
        model_reset();
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("rst");
        @(negedge clk);
        reset = 1'b0;

        // Round-robin streaming on unit 0; fixed priority 1 vs 3 on unit 1.
        sv[0] = 4'hF; sd[0] = 32'h4332_2110; sr[0] = 1'b1;
        sv[1] = 4'b1010; sd[1] = 32'hD4C3_B2A1; sr[1] = 1'b1;
        sv[2] = 4'h0; sr[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_stream_sel", obs_sel(0), 32'(k % 4));
            chk("rr_stream_data", obs_data(0), 32'(rrdat[k % 4]));
            chk("fixed_prio_sel", obs_sel(1), 32'd1);
        end

        // Back-pressure: hold A5 from channel 2, then release into channel 3.
        sv[0] = 4'b0100; sd[0] = 32'h3C_A5_0000;
        cycle();
        chk("bp_load_data", obs_data(0), 32'hA5);
        sv[0] = 4'b1000; sr[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_hold_data", obs_data(0), 32'hA5);
            chk("bp_hold_sel", obs_sel(0), 32'd2);
        end
        sr[0] = 1'b1;
        cycle();
        chk("bp_release_sel", obs_sel(0), 32'd3);
        chk("bp_release_data", obs_data(0), 32'h3C);

        // Wrap on N=3: grant 2, then pointer must be back at 0.
        sd[2] = 32'h00_CC_BB_AA;
        sv[2] = 4'b0100; cycle(); chk("wrap_g2", obs_sel(2), 32'd2);
        sv[2] = 4'b0111; cycle(); chk("wrap_g0", obs_sel(2), 32'd0);
        sv[2] = 4'b0001; cycle(); chk("wrap_only0", obs_sel(2), 32'd0);
        sv[2] = 4'b0111; cycle(); chk("wrap_next1", obs_sel(2), 32'd1);

        // Idle drains the output register.
        for (int u = 0; u < 3; u++) begin sv[u] = 4'h0; sr[u] = 1'b1; end
        cycle();
        chk("idle_valid", obs_valid(0), 32'd0);

        // Async reset between edges while a word is held.
        sv[0] = 4'b0001; sd[0] = 32'h0000_0077;
        cycle();
        sv[0] = 4'b0000; sr[0] = 1'b0;
        cycle();
        chk("held_before_reset", obs_valid(0), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_rst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        sv[0] = 4'b0101; sd[0] = 32'h0033_0011; sr[0] = 1'b1;
        cycle();
        chk("ptr_after_reset", obs_sel(0), 32'd0);

        // Randomised traffic on all units.
        for (int k = 0; k < 400; k++) begin
            for (int u = 0; u < 3; u++) begin
                sv[u] = 4'($urandom);
                sd[u] = $urandom;
                sr[u] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arb_nto1.md
# mux_arb_nto1

Registered N-to-1 multiplexer with valid/ready handshakes and round-robin or fixed-priority arbitration. It generalises the datapath 2:1 byte select to N sources of WIDTH bits. It is used where several CPU-side producers share one consumer, for example ALU/memory/immediate result writeback into the register file bus. It holds one output word in a register and sustains one transfer per cycle under back-pressure.

## Interface
- WIDTH, 8, data width of every channel (≥1)
- N, 4, number of input channels (≥1; non-power-of-2 allowed)
- RR, 1, 1 = round-robin arbitration, 0 = fixed priority (channel 0 highest)
- SEL_W, derived = max(1, ceil(log2 N)), width of channel index
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  N  per-channel request; bit i belongs to channel i
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  N  per-channel accept; at most one bit high
- out_valid  out  1  output register holds a word
- out_data  out  WIDTH  registered selected word
- out_sel  out  SEL_W  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts out_data this cycle

## Operation
- load = !out_valid || out_ready. This signal is combinational and means the output register may be written this edge.
- Grant, combinational:
  - RR=1: the lowest index i ≥ ptr with in_valid[i], otherwise wrapping to the lowest i < ptr.
  - RR=0: the lowest i with in_valid[i].
- in_ready[g] = load && in_valid[g] for the granted g. All other bits are 0. in_ready depends combinationally on in_valid and out_ready only.
- Transfer on channel g when in_valid[g] && in_ready[g]. At the edge:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - If RR=1: ptr <= (g == N-1) ? 0 : g+1.
- load with no in_valid: out_valid <= 0. out_data and out_sel hold their stale values.
- !load (out_valid && !out_ready): out_valid, out_data and out_sel all hold. All in_ready = 0 and ptr holds.
- Output handshake: a word is consumed on out_valid && out_ready. It is consumed exactly once.
- Sources must keep in_valid and in_data stable until accepted. The block does not check this.
- ptr is internal, SEL_W wide, and never exceeds N-1.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system): out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=0 while reset=1.
- Latency: an input accepted at edge k is visible on out_data/out_valid after edge k.
- Throughput: 1 word/cycle when out_ready is held high. Simultaneous consume and refill in the same cycle is required.
- Fairness, RR=1: with all N requesting continuously, the grant sequence is ptr, ptr+1, …, N-1, 0, …. Each channel waits at most N-1 grants.
- Wrap: with N=3 and g=2, ptr becomes 0. No out-of-range index may be produced.
- N=1: the grant is always channel 0, ptr is constant 0, and out_sel=0.
- Reset mid-operation: a held output word is discarded and out_valid drops immediately (asynchronously). The arbitration pointer returns to 0.

## Structure
- Shared package/header holds the clog2-based SEL_W helper and the RR/FIXED mode constants. These are reused by later bus blocks.
- One sub-module, arb_rr_pick: a purely combinational picker with inputs req[N], ptr, and mode, and outputs gnt_idx and gnt_any. The top level holds the output register, the pointer, and the data select.

## Test plan
- Reset: assert reset with in_valid=4'b1111 → out_valid=0, in_ready=0, out_data=8'h00. After release, the first grant is channel 0.
- Round-robin streaming: N=4, all valid, data 8'h10/8'h21/8'h32/8'h43, out_ready=1 → out_sel sequence 0,1,2,3,0,… with one word per cycle and matching out_data.
- Back-pressure: out_ready=0 for 3 cycles while holding 8'hA5 from channel 2 → out_data stays 8'hA5, in_ready=0. When out_ready=1, the same edge loads the next requester (3).
- Fixed priority (RR=0): channels 1 and 3 both valid continuously → channel 1 is always granted and channel 3 is starved.
- Wrap and odd N: N=3, request only channel 2 then only channel 0 → ptr wraps to 0 and the grants are 2 then 0. out_sel is never 3.
- Idle and async reset mid-stream: drop all in_valid with out_ready=1 → out_valid=0 next cycle. Then assert reset between clock edges while out_valid=1 → out_valid falls immediately and ptr=0 after release.
